// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for clock_period_meter: state encodings and the
// counter limit helper used by the measurement FSM.
package clock_period_meter_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE    = 1'b0;
  localparam state_t ST_MEASURE = 1'b1;

  localparam int MIN_SYNC_STAGES = 2;

  // Largest value a width-bit counter can hold before it would wrap.
  function automatic longint unsigned max_count(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/signal_synchronizer.sv
// Generic flip-flop chain for bringing an asynchronous level into the clk
// domain; resets to 0 asynchronously.
module signal_synchronizer
  import clock_period_meter_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  // Fewer than two stages gives no metastability margin, so clamp upwards.
  localparam int DEPTH = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[DEPTH-2:0], din};
    end
  end

  assign dout = chain[DEPTH-1];

endmodule

// File: rtl/clock_period_meter.sv
// Measures period (and, with CLOCK_PERIOD_METER_DUTY_EN defined, high time)
// of an asynchronous input clock in cycles of clk; reset is active-low.
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_clk,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(max_count(WIDTH));
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             s;
  logic             s_d;
  logic             rise;
  logic             at_limit;
  state_t           state;
  logic [WIDTH-1:0] cnt;

  signal_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (in_clk),
    .dout (s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign rise     = s & ~s_d;
  assign at_limit = (cnt == MAX_CNT);

  // A rise on the limit cycle still counts as a measurement; only a missing
  // edge at the limit abandons the run and waits for a fresh arming edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      period   <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            cnt   <= ONE;
            state <= ST_MEASURE;
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          if (rise) begin
            period   <= cnt;
            valid    <= 1'b1;
            overflow <= 1'b0;
            cnt      <= ONE;
          end else if (at_limit) begin
            overflow <= 1'b1;
            cnt      <= '0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
      endcase
    end
  end

`ifdef CLOCK_PERIOD_METER_DUTY_EN
  logic [WIDTH-1:0] hcnt;

  // hcnt tracks cnt's restarts exactly, so it can never exceed cnt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt      <= '0;
      high_time <= '0;
    end else if (state == ST_IDLE) begin
      hcnt <= rise ? ONE : '0;
    end else if (rise) begin
      high_time <= hcnt;
      hcnt      <= ONE;
    end else if (at_limit) begin
      hcnt <= '0;
    end else begin
      hcnt <= hcnt + {{(WIDTH-1){1'b0}}, s};
    end
  end
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter (WIDTH=8): a timestamp model of
// in_clk rising edges predicts each valid's period and high time.
module tb_clock_period_meter;

  localparam int W    = 8;
  localparam int MAXC = 255;

  logic         clk     = 1'b0;
  logic         reset   = 1'b0;
  logic         inClk   = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] highTime;
  logic         valid;
  logic         overflow;

  clock_period_meter #(
    .WIDTH      (W),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_clk   (inClk),
    .period   (period),
    .high_time(highTime),
    .valid    (valid),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int per;
    int hi;
    bit chained;
  } expT;

  expT sb[$];
  expT modelExp;
  expT monExp;

  int numChecks    = 0;
  int numErrors    = 0;
  int cyc          = 0;
  int lastRise     = 0;
  int highs        = 0;
  int lastValidCyc = 0;
  bit armed        = 1'b0;
  bit chainedM     = 1'b0;
  bit prevSample   = 1'b0;
  bit validQ       = 1'b0;
  bit found        = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int expHigh(input int h);
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    return h;
`else
    return 0;
`endif
  endfunction

  task automatic applyStimulus(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inClk = ((i % per) < hi);
    end
  endtask

  // Model: a rise within MAXC cycles of the previous one yields a measurement.
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      armed      = 1'b0;
      chainedM   = 1'b0;
      prevSample = 1'b0;
      highs      = 0;
      sb.delete();
    end else begin
      if (inClk && !prevSample) begin
        if (armed && (cyc - lastRise) <= MAXC) begin
          modelExp.per     = cyc - lastRise;
          modelExp.hi      = highs;
          modelExp.chained = chainedM;
          sb.push_back(modelExp);
          chainedM = 1'b1;
        end else begin
          chainedM = 1'b0;
        end
        armed    = 1'b1;
        lastRise = cyc;
        highs    = 0;
      end
      if (armed && inClk) highs++;
      prevSample = inClk;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      validQ = 1'b0;
    end else begin
      if (valid) begin
        checkOutput("valid_gap", validQ, 0);
        checkOutput("sb_pending", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          monExp = sb.pop_front();
          checkOutput("period", period, monExp.per);
          checkOutput("high_time", highTime, expHigh(monExp.hi));
          checkOutput("valid_ovf", overflow, 0);
          if (monExp.chained) checkOutput("valid_spacing", cyc - lastValidCyc, monExp.per);
        end
        lastValidCyc = cyc;
      end
      validQ = valid;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", numChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inClk = ~inClk;
      checkOutput("rst_period", period, 0);
      checkOutput("rst_high", highTime, 0);
      checkOutput("rst_valid", valid, 0);
      checkOutput("rst_ovf", overflow, 0);
    end
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(10, 5, 100);
    applyStimulus(4, 2, 40);
    applyStimulus(8, 4, 80);

    // Stuck low: overflow must appear exactly MAXC cycles after the last valid.
    inClk = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (overflow) begin
        found = 1'b1;
        checkOutput("ovf_dist", cyc - lastValidCyc, MAXC);
      end
    end
    checkOutput("ovf_seen", found, 1);
    checkOutput("ovf_period_hold", period, 8);
    checkOutput("ovf_high_hold", highTime, expHigh(4));
    repeat (20) @(negedge clk);
    checkOutput("ovf_sticky", overflow, 1);

    applyStimulus(10, 5, 40);
    checkOutput("ovf_cleared", overflow, 0);

    applyStimulus(255, 3, 510);
    applyStimulus(256, 3, 512);
    checkOutput("gap256_ovf", overflow, 1);

    applyStimulus(10, 5, 45);
    checkOutput("pre_rst_period", period, 10);
    checkOutput("pre_rst_ovf", overflow, 0);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_period", period, 0);
    checkOutput("mid_rst_high", highTime, 0);
    checkOutput("mid_rst_valid", valid, 0);
    checkOutput("mid_rst_ovf", overflow, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    applyStimulus(10, 5, 60);
    checkOutput("post_rst_period", period, 10);
    inClk = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
    $finish;
  end

endmodule
